hv_bundler: RTL and testbench

HV_BUNDLER -- requirements
Module: hv_bundler

---
 rtl/hdc_pkg.sv | 15 +
 rtl/hv_count_lane.sv | 35 +++
 rtl/hv_bundler.sv | 116 +++++++++++
 tb/tb_hv_bundler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing definitions: default hypervector geometry
// and the bundler control state encoding.
package hdc_pkg;

    localparam int DIM   = 64;  // hypervector width, one bit per dimension
    localparam int CNT_W = 8;   // per-dimension counter and sample-count width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        THRESH = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/hv_count_lane.sv
// One dimension of the bundler: counts how many accepted hypervectors had this
// bit set (saturating) and reports whether that count is a strict majority.
module hv_count_lane #(
    parameter int CNT_W = hdc_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,   // start of a new bundle
    input  logic             i_inc,   // a beat is accepted this cycle
    input  logic             i_bit,   // this dimension's bit of the beat
    input  logic [CNT_W-1:0] i_num,   // latched number of samples
    output logic             o_maj    // 2*count > num
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    // Saturating set-bit counter, cleared when a new bundle starts
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so every lane and the control FSM see the pre-edge value of each other's state.
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && i_bit && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Doubling is done one bit wider so a full counter cannot wrap; ties give 0
    assign o_maj = ({r_cnt, 1'b0} > {1'b0, i_num});

endmodule

// File: rtl/hv_bundler.sv
// Majority bundler: accepts num_samples binary hypervectors over a valid/ready
// stream, counts set bits per dimension, then thresholds at a strict majority
// and presents the bundled hypervector until the consumer takes it.
module hv_bundler #(
    parameter int DIM   = hdc_pkg::DIM,
    parameter int CNT_W = hdc_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             hv_valid,
    output logic             hv_ready,
    input  logic [DIM-1:0]   hv_in,
    output logic             bundle_valid,
    input  logic             bundle_ready,
    output logic [DIM-1:0]   bundle_hv,
    output logic             busy
);

    import hdc_pkg::state_t;
    import hdc_pkg::IDLE;
    import hdc_pkg::ACCUM;
    import hdc_pkg::THRESH;
    import hdc_pkg::DONE;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_beat;
    logic [DIM-1:0]   r_bundle_hv;
    logic [DIM-1:0]   w_maj;
    logic             w_start_ok;
    logic             w_accept;
    logic             w_last;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_accept   = hv_valid && hv_ready;
    // r_num is at least 1 whenever ACCUM is entered, so r_num-1 cannot wrap here
    assign w_last     = (r_beat == (r_num - CNT_ONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves w_next unassigned (no latch).
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = (num_samples == '0) ? THRESH : ACCUM;
            ACCUM:   if (w_accept && w_last) w_next = THRESH;
            THRESH:  w_next = DONE;
            DONE:    if (bundle_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        hv_ready     = 1'b0;
        bundle_valid = 1'b0;
        busy         = 1'b1;
        unique case (r_state)
            IDLE:    busy = 1'b0;
            ACCUM:   hv_ready = 1'b1;
            THRESH:  ;
            DONE:    bundle_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Latched sample count, beat counter and registered bundle result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num       <= '0;
            r_beat      <= '0;
            r_bundle_hv <= '0;
        end else begin
            if (w_start_ok) begin
                r_num  <= num_samples;
                r_beat <= '0;
            end else if (w_accept) begin
                r_beat <= r_beat + CNT_ONE;
            end
            // Result is captured only on the THRESH exit edge and held otherwise
            if (r_state == THRESH) begin
                r_bundle_hv <= w_maj;
            end
        end
    end

    for (genvar d = 0; d < DIM; d++) begin : g_lane
        hv_count_lane #(
            .CNT_W (CNT_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .i_clr (w_start_ok),
            .i_inc (w_accept),
            .i_bit (hv_in[d]),
            .i_num (r_num),
            .o_maj (w_maj[d])
        );
    end

    assign bundle_hv = r_bundle_hv;

endmodule

// File: tb/tb_hv_bundler.sv
// Directed bench for hv_bundler: stimulus pushes hand-computed bundles into a
// queue, a negedge monitor pops and compares whenever bundle_valid rises.
module tb_hv_bundler;

    localparam int DIM   = 64;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             hv_valid;
    logic             hv_ready;
    logic [DIM-1:0]   hv_in;
    logic             bundle_valid;
    logic             bundle_ready;
    logic [DIM-1:0]   bundle_hv;
    logic             busy;

    hv_bundler #(
        .DIM   (DIM),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_samples  (num_samples),
        .hv_valid     (hv_valid),
        .hv_ready     (hv_ready),
        .hv_in        (hv_in),
        .bundle_valid (bundle_valid),
        .bundle_ready (bundle_ready),
        .bundle_hv    (bundle_hv),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: sample at negedge, pop on bundle_valid rise, check value,
    // latency (2 cycles after the final beat or zero-sample start) and hold.
    int          cyc  = 0;
    int          trig = 0;
    logic        seen = 1'b0;
    logic [63:0] held = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (start && !busy) trig = cyc;
            if (hv_valid && hv_ready) trig = cyc;
            if (bundle_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_bundle", 64'(bundle_valid), 64'd0);
                        held = bundle_hv;
                    end else begin
                        held = exp_q.pop_front();
                        check("bundle_hv", bundle_hv, held);
                        check("latency", 64'(cyc - trig), 64'd2);
                    end
                end else begin
                    check("bundle_hold", bundle_hv, held);
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic do_start(input int n);
        @(posedge clk); #1;
        start       = 1'b1;
        num_samples = CNT_W'(n);
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] hv);
        int guard = 0;
        hv_valid = 1'b1;
        hv_in    = hv;
        while (!hv_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("beat_ready", 64'(hv_ready), 64'd1);
        @(posedge clk); #1;
        hv_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("gap_ready", 64'(hv_ready), 64'd1);
        end
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!bundle_valid && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        check("valid_timeout", 64'(bundle_valid), 64'd1);
    endtask

    // Hold bundle_ready low for 'hold' cycles (with ignored start pulses), then take it
    task automatic ack(input int hold);
        wait_valid();
        for (int i = 0; i < hold; i++) begin
            start       = (i == 3 || i == 7);
            num_samples = 8'd2;
            @(posedge clk); #1;
            check("hold_valid", 64'(bundle_valid), 64'd1);
        end
        start        = 1'b0;
        bundle_ready = 1'b1;
        @(posedge clk); #1;
        bundle_ready = 1'b0;
        check("ack_valid", 64'(bundle_valid), 64'd0);
        check("ack_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        num_samples  = '0;
        hv_valid     = 1'b0;
        hv_in        = '0;
        bundle_ready = 1'b0;
        #1;
        check("rst_ready", 64'(hv_ready), 64'd0);
        check("rst_valid", 64'(bundle_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hv", bundle_hv, 64'd0);
        #21 rst_n = 1'b1;

        // 3 back-to-back beats: bits 0,1 set in 3 and 2 of 3 -> 0x3
        do_start(3);
        check("accum_busy", 64'(busy), 64'd1);
        exp_q.push_back(64'h0000_0000_0000_0003);
        send_beat(64'h0F);
        send_beat(64'h03);
        send_beat(64'h01);
        ack(0);

        // 4 beats: bit0 in 2 of 4 (tie -> 0), bit1 in 3 of 4 -> 0x2
        do_start(4);
        exp_q.push_back(64'h0000_0000_0000_0002);
        send_beat(64'h3);
        send_beat(64'h2);
        send_beat(64'h3);
        send_beat(64'h0);
        ack(0);

        // 2 beats ungapped then gapped: only bits set in both survive -> 0xF000
        do_start(2);
        exp_q.push_back(64'h0000_0000_0000_F000);
        send_beat(64'hF0F0);
        send_beat(64'hFF00);
        ack(0);
        do_start(2);
        exp_q.push_back(64'h0000_0000_0000_F000);
        send_beat(64'hF0F0);
        gap(5);
        send_beat(64'hFF00);
        ack(0);

        // Single sample is its own majority; consumer stalls 10 cycles
        do_start(1);
        exp_q.push_back(64'hDEAD_BEEF_0123_4567);
        send_beat(64'hDEAD_BEEF_0123_4567);
        ack(10);

        // 255 all-ones samples -> all-ones
        do_start(255);
        exp_q.push_back({64{1'b1}});
        for (int i = 0; i < 255; i++) send_beat({64{1'b1}});
        ack(0);

        // Reset after 2 of 5 beats discards the partial bundle asynchronously
        do_start(5);
        send_beat(64'hFF);
        send_beat(64'hFF);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(hv_ready), 64'd0);
        check("arst_valid", 64'(bundle_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hv", bundle_hv, 64'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_busy", 64'(busy), 64'd0);
        end
        do_start(1);
        exp_q.push_back(64'h0000_0000_0000_00A5);
        send_beat(64'hA5);
        ack(0);

        // Zero samples: no beats accepted, result 0 (previous result was 0xA5)
        @(posedge clk); #1;
        start       = 1'b1;
        num_samples = '0;
        exp_q.push_back(64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("zero_ready", 64'(hv_ready), 64'd0);
            @(posedge clk); #1;
        end
        ack(0);

        repeat (2) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
